dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port 256x8 data memory. It shares the memory between the CPU load/store unit (port A) and the debug/program-loader port (port B). It grants at most one access per cycle using round-robin, with an optional bounded lock for bursts, and drives the memory's write-enable, address and data. Read data returns one cycle after the grant, tagged to the requester that issued the read.

---
 rtl/dmem_arbiter_if.sv | 34 +++
 rtl/dmem_arbiter.sv | 93 +++++++++
 tb/tb_dmem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Request/grant/read-return bundle between the two memory requesters (CPU port A, debug port B) and the arbiter.
// Commands are held by the requester until the matching gnt is seen high at a clock edge.
interface dmem_arbiter_if;
  logic       a_req;
  logic       a_we;
  logic [7:0] a_addr;
  logic [7:0] a_wdata;
  logic       a_gnt;
  logic       a_rvalid;
  logic [7:0] a_rdata;

  logic       b_req;
  logic       b_we;
  logic [7:0] b_addr;
  logic [7:0] b_wdata;
  logic       b_lock;
  logic       b_gnt;
  logic       b_rvalid;
  logic [7:0] b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata, b_lock,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata, b_lock,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for a single-port 256x8 memory with a bounded burst lock on port B.
// Grant is combinational (0 wait uncontended); read data returns one cycle after grant; losers simply hold their request.
module dmem_arbiter #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus,
  output logic           mem_write_en,
  output logic [7:0]     mem_addr,
  output logic [7:0]     mem_data_in,
  input  logic [7:0]     mem_data_out
);

  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  logic       last_b;
  logic [7:0] lock_cnt;
  logic [1:0] rd_owner;

  logic       a_gnt;
  logic       b_gnt;
  logic       lock_active;
  logic       a_rvalid;
  logic       b_rvalid;

  always_comb begin
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    lock_active = bus.b_lock && last_b && (lock_cnt < LOCK_LIM);
    if (!reset) begin
      if (bus.a_req && bus.b_req) begin
        // Under contention B wins either by holding a live lock or by round-robin turn.
        if (lock_active || !last_b) begin
          b_gnt = 1'b1;
        end else begin
          a_gnt = 1'b1;
        end
      end else begin
        a_gnt = bus.a_req;
        b_gnt = bus.b_req;
      end
    end
  end

  always_comb begin
    mem_write_en = 1'b0;
    mem_addr     = bus.a_addr;
    mem_data_in  = bus.a_wdata;
    if (b_gnt) begin
      mem_write_en = bus.b_we;
      mem_addr     = bus.b_addr;
      mem_data_in  = bus.b_wdata;
    end else if (a_gnt) begin
      mem_write_en = bus.a_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_b   <= 1'b1;
      lock_cnt <= 8'd0;
      rd_owner <= 2'b00;
    end else begin
      if (a_gnt) begin
        last_b <= 1'b0;
      end else if (b_gnt) begin
        last_b <= 1'b1;
      end

      // Only a locked B grant following a B grant extends the run; it saturates when A is idle.
      if (b_gnt && bus.b_lock && last_b) begin
        lock_cnt <= (lock_cnt < LOCK_LIM) ? lock_cnt + 8'd1 : lock_cnt;
      end else begin
        lock_cnt <= 8'd0;
      end

      rd_owner <= {b_gnt && !bus.b_we, a_gnt && !bus.a_we};
    end
  end

  // Reset masks the return path so a read granted just before reset never reports.
  assign a_rvalid = rd_owner[0] && !reset;
  assign b_rvalid = rd_owner[1] && !reset;

  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.a_rvalid = a_rvalid;
  assign bus.b_rvalid = b_rvalid;
  assign bus.a_rdata  = a_rvalid ? mem_data_out : 8'd0;
  assign bus.b_rdata  = b_rvalid ? mem_data_out : 8'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: per-port command queues drive the bus, a reference model predicts
// grants and read data, and a separate monitor matches read returns against the expected queues.
module tb_dmem_arbiter;
  localparam int LOCK_MAX = 4;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       lock;
  } cmd_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       mem_write_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cmd_t a_cmds[$];
  cmd_t b_cmds[$];
  exp_t exp_a[$];
  exp_t exp_b[$];
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  bit a_taken = 0;
  bit b_taken = 0;

  bit m_last_b = 1;
  int m_streak = 0;
  int b_run = 0;
  int max_b_run = 0;

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  function automatic cmd_t mk(bit we, bit [7:0] addr, bit [7:0] wdata, bit lock);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata; c.lock = lock;
    return c;
  endfunction

  function automatic cmd_t rand_cmd(bit allow_lock);
    cmd_t c;
    c.we    = 1'($urandom_range(0, 1));
    c.addr  = 8'($urandom_range(0, 7));
    c.wdata = 8'($urandom);
    c.lock  = allow_lock && ($urandom_range(0, 1) == 1);
    return c;
  endfunction

  // Memory behaviour: write at the edge, registered read of the presented address.
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr] <= mem_data_in;
    mem_data_out <= mem[mem_addr];
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    a_taken = bus.a_gnt;
    b_taken = bus.b_gnt;
  end

  // Requester driver: hold the head command until granted, then move on.
  always @(posedge clk) begin
    #1;
    if (a_taken && a_cmds.size() > 0) void'(a_cmds.pop_front());
    if (b_taken && b_cmds.size() > 0) void'(b_cmds.pop_front());
    a_taken = 0;
    b_taken = 0;
    if (a_cmds.size() > 0) begin
      bus.a_req = 1'b1; bus.a_we = a_cmds[0].we; bus.a_addr = a_cmds[0].addr; bus.a_wdata = a_cmds[0].wdata;
    end else begin
      bus.a_req = 1'b0;
    end
    if (b_cmds.size() > 0) begin
      bus.b_req = 1'b1; bus.b_we = b_cmds[0].we; bus.b_addr = b_cmds[0].addr;
      bus.b_wdata = b_cmds[0].wdata; bus.b_lock = b_cmds[0].lock;
    end else begin
      bus.b_req = 1'b0; bus.b_lock = 1'b0;
    end
  end

  // Reference model: decide the winner from the arbitration rules, then predict memory side effects.
  always @(negedge clk) begin
    int win;
    if (reset) begin
      m_last_b = 1; m_streak = 0; b_run = 0;
      exp_a.delete(); exp_b.delete();
      check("rst_a_gnt", bus.a_gnt, 0);
      check("rst_b_gnt", bus.b_gnt, 0);
      check("rst_mem_we", mem_write_en, 0);
    end else begin
      if (bus.a_req && bus.b_req) begin
        if (bus.b_lock && m_last_b && m_streak < LOCK_MAX) win = 2;
        else win = m_last_b ? 1 : 2;
      end else begin
        win = bus.a_req ? 1 : (bus.b_req ? 2 : 0);
      end
      check("a_gnt", bus.a_gnt, win == 1);
      check("b_gnt", bus.b_gnt, win == 2);
      if (win == 1) begin
        check("mem_we_a", mem_write_en, bus.a_we);
        check("mem_addr_a", mem_addr, bus.a_addr);
        if (bus.a_we) begin
          check("mem_din_a", mem_data_in, bus.a_wdata);
          ref_mem[bus.a_addr] = bus.a_wdata;
        end else begin
          exp_a.push_back('{cyc + 1, ref_mem[bus.a_addr]});
        end
        m_last_b = 0; m_streak = 0;
      end else if (win == 2) begin
        check("mem_we_b", mem_write_en, bus.b_we);
        check("mem_addr_b", mem_addr, bus.b_addr);
        if (bus.b_we) begin
          check("mem_din_b", mem_data_in, bus.b_wdata);
          ref_mem[bus.b_addr] = bus.b_wdata;
        end else begin
          exp_b.push_back('{cyc + 1, ref_mem[bus.b_addr]});
        end
        if (bus.b_lock && m_last_b) m_streak = (m_streak < LOCK_MAX) ? m_streak + 1 : LOCK_MAX;
        else m_streak = 0;
        m_last_b = 1;
      end else begin
        check("idle_mem_we", mem_write_en, 0);
        check("idle_mem_addr", mem_addr, bus.a_addr);
        m_streak = 0;
      end
      b_run = (win == 2) ? b_run + 1 : 0;
      if (b_run > max_b_run) max_b_run = b_run;
    end
  end

  // Monitor: match every read return to the oldest expectation of that port.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("rst_a_rvalid", bus.a_rvalid, 0);
      check("rst_b_rvalid", bus.b_rvalid, 0);
      check("rst_a_rdata", bus.a_rdata, 0);
      check("rst_b_rdata", bus.b_rdata, 0);
    end else begin
      if (bus.a_rvalid) begin
        if (exp_a.size() == 0) check("a_rvalid_unexpected", bus.a_rvalid, 0);
        else begin
          e = exp_a.pop_front();
          check("a_rvalid_cycle", cyc, e.cyc);
          check("a_rdata", bus.a_rdata, e.data);
        end
      end else begin
        check("a_rdata_idle", bus.a_rdata, 0);
        if (exp_a.size() > 0 && exp_a[0].cyc <= cyc) begin
          check("a_rvalid_missing", bus.a_rvalid, 1);
          void'(exp_a.pop_front());
        end
      end
      if (bus.b_rvalid) begin
        if (exp_b.size() == 0) check("b_rvalid_unexpected", bus.b_rvalid, 0);
        else begin
          e = exp_b.pop_front();
          check("b_rvalid_cycle", cyc, e.cyc);
          check("b_rdata", bus.b_rdata, e.data);
        end
      end else begin
        check("b_rdata_idle", bus.b_rdata, 0);
        if (exp_b.size() > 0 && exp_b[0].cyc <= cyc) begin
          check("b_rvalid_missing", bus.b_rvalid, 1);
          void'(exp_b.pop_front());
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((a_cmds.size() > 0 || b_cmds.size() > 0 || exp_a.size() > 0 || exp_b.size() > 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n >= 2000, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'd0;
      ref_mem[i] = 8'd0;
    end
    reset = 1'b1;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0; bus.b_lock = 0;

    // Commands queued during reset must stay ungranted until release.
    a_cmds.push_back(mk(1, 8'h10, 8'h5A, 0));
    a_cmds.push_back(mk(0, 8'h10, 8'h00, 0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    drain();

    // Alternating contention on reads.
    a_cmds.push_back(mk(1, 8'h01, 8'h11, 0));
    a_cmds.push_back(mk(1, 8'h02, 8'h22, 0));
    drain();
    for (int i = 0; i < 6; i++) begin
      a_cmds.push_back(mk(0, 8'h01, 8'h00, 0));
      b_cmds.push_back(mk(0, 8'h02, 8'h00, 0));
    end
    drain();
    a_cmds.push_back(mk(0, 8'h03, 8'h00, 0));
    drain();

    // Bounded lock: B wins once by turn, then holds LOCK_MAX locked grants.
    max_b_run = 0;
    for (int i = 0; i < 10; i++) begin
      a_cmds.push_back(mk(0, 8'h01, 8'h00, 0));
      b_cmds.push_back(mk(0, 8'h02, 8'h00, 1));
    end
    drain();
    check("lock_run_len", max_b_run, LOCK_MAX + 1);

    // Long lock with A idle, then A arrives.
    max_b_run = 0;
    for (int i = 0; i < 320; i++) b_cmds.push_back(mk(0, 8'($urandom_range(0, 7)), 8'h00, 1));
    repeat (300) @(negedge clk);
    check("idle_lock_run", max_b_run >= 295, 1);
    a_cmds.push_back(mk(0, 8'h01, 8'h00, 0));
    w = 0; n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (bus.a_req && bus.a_gnt) break;
      if (bus.a_req) w++;
    end
    check("a_wait_bound", (n < 50) && (w <= LOCK_MAX), 1);
    drain();

    // Reset right after a read grant; pending commands survive into the first contention.
    a_cmds.push_back(mk(0, 8'h10, 8'h00, 0));
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (bus.a_gnt) break;
    end
    check("pre_reset_grant", bus.a_gnt, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    b_cmds.push_back(mk(1, 8'h40, 8'h99, 0));
    a_cmds.push_back(mk(0, 8'h40, 8'h00, 0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_a_first", {bus.a_gnt, bus.b_gnt}, 2'b10);
    drain();

    // Same-cycle B write / A read to one address with B holding the turn.
    a_cmds.push_back(mk(0, 8'h30, 8'h00, 0));
    drain();
    b_cmds.push_back(mk(1, 8'h20, 8'h77, 0));
    a_cmds.push_back(mk(0, 8'h20, 8'h00, 0));
    n = 0;
    while (n < 20 && !(bus.a_req && bus.b_req)) begin
      @(negedge clk);
      n++;
    end
    check("raw_b_first", {bus.a_gnt, bus.b_gnt}, 2'b01);
    drain();
    check("raw_ref_value", ref_mem[8'h20], 8'h77);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 2) != 0 && a_cmds.size() < 3) a_cmds.push_back(rand_cmd(0));
      if ($urandom_range(0, 2) != 0 && b_cmds.size() < 3) b_cmds.push_back(rand_cmd(1));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
